// File: rtl/miliseg_gen.sv
// miliseg_gen: millisecond timebase for the wall-clock/alarm datapath.
// Divides clk into 1 ms steps and counts 0..MS_PER_SEC-1. On each second
// rollover it presents miliseg == MS_PER_SEC for exactly one cycle, then 0.
// Supports run/pause, synchronous clear and single-ms trim for calibration.
// Optional build macro: MILISEG_FAST_SIM_EN bypasses the prescaler so that
// every COUNT cycle with run high is a millisecond step.
module miliseg_gen #(
    parameter int CLKS_PER_MS = 10000,
    parameter int MS_PER_SEC  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        clear,
    input  logic        trim_up,
    input  logic        trim_down,
    output logic [31:0] miliseg,
    output logic        ms_tick,
    output logic        sec_tick,
    output logic        running
);

    localparam int PRE_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_MS - 1);
    localparam logic signed [33:0] MS_LIM = 34'(MS_PER_SEC);
    localparam logic [31:0] MS_WRAP_VAL = 32'(MS_PER_SEC);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_WRAP  = 2'd2;

    logic [1:0]       r_state;
    logic [PRE_W-1:0] r_pre_cnt;
    logic             r_step_pending;
    logic [31:0]      r_miliseg;
    logic             r_ms_tick;
    logic             r_sec_tick;
    logic             r_running;

    logic [1:0]         w_state_nxt;
    logic [PRE_W-1:0]   w_pre_nxt;
    logic               w_pend_nxt;
    logic [31:0]        w_ms_nxt;
    logic               w_pre_hit;
    logic [PRE_W-1:0]   w_pre_adv;
    logic               w_step_now;
    logic signed [33:0] w_sum;
    logic               w_over;
    logic [31:0]        w_sat;

`ifdef MILISEG_FAST_SIM_EN
    assign w_pre_hit  = 1'b0;
    assign w_pre_adv  = '0;
    assign w_step_now = (r_state == S_COUNT) && run;
`else
    assign w_pre_hit  = (r_pre_cnt == PRE_MAX);
    assign w_pre_adv  = w_pre_hit ? '0 : r_pre_cnt + 1'b1;
    // A prescaler wrap that fell inside WRAP is parked and consumed by the
    // first COUNT cycle, so the 0 -> 1 step is late but never lost.
    assign w_step_now = (r_state == S_COUNT) && run && (w_pre_hit || r_step_pending);
`endif

    // Signed sum so that a trim_down at 0 can be detected and saturated.
    assign w_sum = $signed({2'b00, r_miliseg})
                 + $signed({33'd0, w_step_now})
                 + $signed({33'd0, trim_up})
                 - $signed({33'd0, trim_down});
    assign w_over = (w_sum >= MS_LIM);
    assign w_sat  = w_sum[33] ? 32'd0 : w_sum[31:0];

    // Next-state logic: clear dominates, WRAP always lasts one cycle, and
    // trims share the same saturating arithmetic in IDLE and COUNT.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre_cnt;
        w_pend_nxt  = r_step_pending;
        w_ms_nxt    = r_miliseg;
        if (clear) begin
            w_state_nxt = run ? S_COUNT : S_IDLE;
            w_pre_nxt   = '0;
            w_pend_nxt  = 1'b0;
            w_ms_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE, S_COUNT: begin
                    if ((r_state == S_COUNT) && run) begin
                        w_pre_nxt  = w_pre_adv;
                        w_pend_nxt = 1'b0;
                    end
                    if (w_over) begin
                        w_state_nxt = S_WRAP;
                        w_ms_nxt    = MS_WRAP_VAL;
                    end else begin
                        w_state_nxt = run ? S_COUNT : S_IDLE;
                        w_ms_nxt    = w_sat;
                    end
                end
                S_WRAP: begin
                    w_state_nxt = run ? S_COUNT : S_IDLE;
                    w_ms_nxt    = '0;
                    if (run) begin
                        w_pre_nxt = w_pre_adv;
                        if (w_pre_hit) begin
                            w_pend_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; status flags are taken from the next state
    // so they line up with the state register in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_pre_cnt      <= '0;
            r_step_pending <= 1'b0;
            r_miliseg      <= '0;
            r_ms_tick      <= 1'b0;
            r_sec_tick     <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pre_cnt      <= w_pre_nxt;
            r_step_pending <= w_pend_nxt;
            r_miliseg      <= w_ms_nxt;
            r_ms_tick      <= w_step_now && !clear;
            r_sec_tick     <= (w_state_nxt == S_WRAP);
            r_running      <= (w_state_nxt != S_IDLE);
        end
    end

    assign miliseg  = r_miliseg;
    assign ms_tick  = r_ms_tick;
    assign sec_tick = r_sec_tick;
    assign running  = r_running;

endmodule

// File: tb/tb_miliseg_gen.sv
// tb_miliseg_gen: self-checking bench for miliseg_gen with CLKS_PER_MS = 4,
// MS_PER_SEC = 1000. Honours MILISEG_FAST_SIM_EN to select the fast build.
module tb_miliseg_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        clear;
    logic        trim_up;
    logic        trim_down;
    logic [31:0] miliseg;
    logic        ms_tick;
    logic        sec_tick;
    logic        running;

    typedef struct {
        int   ms;
        logic tick;
        logic sec;
        logic rn;
    } exp_t;

    typedef struct {
        logic run;
        logic clr;
        logic up;
        logic dn;
        int   ms;
        logic tick;
        logic sec;
        logic rn;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[17];
    int   total = 0;
    int   bad   = 0;

    miliseg_gen #(
        .CLKS_PER_MS (4),
        .MS_PER_SEC  (1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .clear     (clear),
        .trim_up   (trim_up),
        .trim_down (trim_down),
        .miliseg   (miliseg),
        .ms_tick   (ms_tick),
        .sec_tick  (sec_tick),
        .running   (running)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    function automatic exp_t mk(input int ms, input logic t, input logic s, input logic r);
        exp_t e;
        e.ms   = ms;
        e.tick = t;
        e.sec  = s;
        e.rn   = r;
        return e;
    endfunction

    // Expected outputs k edges after a clear with run high (prescaler of 4)
    function automatic exp_t freeExp(input int k);
        exp_t e;
        e.ms   = (k == 4000) ? 1000 : (k / 4) % 1000;
        e.tick = (k > 0) && (k % 4 == 0);
        e.sec  = (k == 4000);
        e.rn   = 1'b1;
        return e;
    endfunction

    // Expected outputs k edges after a clear with run high in the fast build
    function automatic exp_t fastExp(input int k);
        exp_t e;
        int   j;
        j      = k % 1001;
        e.ms   = j;
        e.tick = (j != 0);
        e.sec  = (j == 1000);
        e.rn   = 1'b1;
        return e;
    endfunction

    task automatic applyStimulus(input logic r, input logic c, input logic u, input logic d,
                                 input exp_t e);
        run       = r;
        clear     = c;
        trim_up   = u;
        trim_down = d;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        clear     = 1'b0;
        trim_up   = 1'b0;
        trim_down = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s: scoreboard empty", name);
        end else begin
            e = sbq.pop_front();
            if (miliseg !== 32'(e.ms) || ms_tick !== e.tick || sec_tick !== e.sec
                || running !== e.rn) begin
                bad++;
                $display("[TB] FAIL %s: got ms=%0d tick=%b sec=%b run=%b, want ms=%0d tick=%b sec=%b run=%b",
                         name, miliseg, ms_tick, sec_tick, running, e.ms, e.tick, e.sec, e.rn);
            end
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic u, input logic d,
                       input int ms, input logic t, input logic s, input logic rn,
                       input string name);
        applyStimulus(r, c, u, d, mk(ms, t, s, rn));
        checkOutput(name);
    endtask

    task automatic freeRun(input int kFrom, input int kTo, input string name);
        for (int k = kFrom; k <= kTo; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, freeExp(k));
            checkOutput(name);
        end
    endtask

    task automatic clearRun();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "clear_run");
    endtask

    // Main sequence: reset, vector table, then the multi-cycle scenarios
    initial begin
        int ticks;
        int secs;
        reset     = 1'b1;
        run       = 1'b0;
        clear     = 1'b0;
        trim_up   = 1'b0;
        trim_down = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        sbq.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        checkOutput("power_on_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

`ifdef MILISEG_FAST_SIM_EN
        clearRun();
        for (int k = 1; k <= 2005; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, fastExp(k));
            checkOutput("fast_run");
        end
`else
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].run, vecs[i].clr, vecs[i].up, vecs[i].dn,
                          mk(vecs[i].ms, vecs[i].tick, vecs[i].sec, vecs[i].rn));
            checkOutput($sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of a count at 517
        clearRun();
        freeRun(1, 2068, "run_to_517");
        #2;
        reset = 1'b0;
        #1;
        sbq.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        checkOutput("async_reset_517");
        run   = 1'b1;
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "rel_enter_count");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "rel_pre1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "rel_pre2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "rel_pre3");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, "rel_first_tick");

        // One full second of free running, including the WRAP cycle
        clearRun();
        ticks = 0;
        secs  = 0;
        for (int k = 1; k <= 4008; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, freeExp(k));
            if (k <= 4000 && ms_tick === 1'b1) ticks++;
            if (sec_tick === 1'b1) secs++;
            checkOutput("free_run");
        end
        total++;
        if (ticks != 1000) begin
            bad++;
            $display("[TB] FAIL tick_count: got %0d, want 1000", ticks);
        end
        total++;
        if (secs != 1) begin
            bad++;
            $display("[TB] FAIL sec_count: got %0d, want 1", secs);
        end

        // Pause at 300 with prescaler at 2, then resume
        clearRun();
        freeRun(1, 1202, "run_to_300");
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 300, 1'b0, 1'b0, 1'b0, "pause_hold");
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 300, 1'b0, 1'b0, 1'b1, "resume_enter");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 300, 1'b0, 1'b0, 1'b1, "resume_pre3");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 301, 1'b1, 1'b0, 1'b1, "resume_step");

        // trim_up at 999 wraps, trim_down at 0 saturates
        clearRun();
        freeRun(1, 3996, "run_to_999");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1000, 1'b0, 1'b1, 1'b1, "trim_up_999");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "wrap_exit");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, "trim_dn_0");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, "step_after_dn");

        // Both trims together cancel
        clearRun();
        freeRun(1, 2000, "run_to_500");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 500, 1'b0, 1'b0, 1'b1, "trim_both_500");

        // trim_up coinciding with a step at 998
        clearRun();
        freeRun(1, 3995, "run_to_998");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1000, 1'b1, 1'b1, 1'b1, "step_up_998");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "wrap_exit_998");

        // Trim-induced WRAP where the prescaler step falls inside WRAP
        clearRun();
        freeRun(1, 3998, "run_to_999_pre2");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1000, 1'b0, 1'b1, 1'b1, "trim_up_pre2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "deferred_wrap_exit");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b1, "deferred_step");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, "deferred_hold1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, "deferred_hold2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1, "deferred_next_step");

        // clear during WRAP, then clear with trim_up at 700 while paused
        clearRun();
        freeRun(1, 4000, "run_to_wrap");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, "clear_in_wrap");
        freeRun(1, 5, "after_clear_wrap");
        clearRun();
        freeRun(1, 2800, "run_to_700");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, "clear_trim_700");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "idle_after_clear");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
